hcp_reg_access_initiator: RTL
=============================

Name: hcp_reg_access_initiator

Overview:
Master side of the HCP register-access bus. It accepts decoded TSMP configuration commands (single write, or read burst with fixed or incrementing address) from the frame parser and issues i_wr/i_rd strobes to the register groups. It collects their o_wr/ov_addr/ov_rdata read responses, with a timeout, and streams read results back to the TSMP encapsulator. Sits between the tsmp_agent parser/encapsulator and all HCP/TSS register groups.

Parameters:
RD_TIMEOUT, 16, cycles to wait for a read response before declaring timeout (range 2..255)
TIMEOUT_DATA, 32'hDEAD_BEEF, data word reported for a timed-out read
ADDR_W, 19, register address width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; asynchronous, active-low; clock i_clk
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  initiator idle, command accepted when valid&ready
iv_cmd_type  in  2  2'b01 write, 2'b10 read, others illegal
iv_cmd_addr  in  19  start address
i_cmd_addr_fixed  in  1  address-space select, forwarded unchanged
iv_cmd_wdata  in  32  write data
iv_cmd_num  in  8  read burst length (0 treated as 1)
i_cmd_incr  in  1  1: address +1 per read beat; 0: same address each beat
o_wr  out  1  write strobe to register groups
o_rd  out  1  read strobe to register groups
ov_addr  out  19  bus address
o_addr_fixed  out  1  bus address-space select
ov_wdata  out  32  bus write data
i_resp_valid  in  1  read response strobe (OR of register-group o_wr)
iv_resp_addr  in  19  response address
i_resp_addr_fixed  in  1  response address-space select
iv_resp_rdata  in  32  response data
o_rdata_valid  out  1  one-cycle result pulse to encapsulator
ov_rdata_addr  out  19  address of result
ov_rdata  out  32  result data
o_rdata_err  out  1  result is a timeout
o_rdata_last  out  1  final beat of burst
ov_timeout_cnt  out  16  saturating timeout counter
o_illegal_cmd  out  1  one-cycle pulse on illegal type

Behaviour:
- All outputs registered; reset: o_cmd_ready=1, all strobes/flags 0, all buses 0, counters 0, FSM IDLE.
- FSM states: IDLE, WR, RD_REQ, RD_WAIT.
- IDLE: o_cmd_ready=1. On valid&ready, latch addr/fixed/wdata/num/incr and set ready=0 in the same edge. Type 01 -> WR. Type 10 -> RD_REQ with beat counter = max(num,1). Other types -> pulse o_illegal_cmd; stay IDLE.
- WR: o_wr=1 for exactly one cycle with latched addr/fixed/wdata; o_rd=0. Then -> IDLE. A write produces no result.
- RD_REQ: o_rd=1 for one cycle with the current addr/fixed; wdata=0. Clear the timeout counter, then -> RD_WAIT.
- RD_WAIT: a response matches only if i_resp_valid, iv_resp_addr==current addr and i_resp_addr_fixed==current fixed. Non-matching responses are ignored. Earliest legal match is the cycle after o_rd is sampled (one-cycle register-group latency).
- On match, next cycle: o_rdata_valid=1, ov_rdata=iv_resp_rdata, err=0, last=(beats remaining==1).
- Timeout: if the wait count reaches RD_TIMEOUT with no match, emit a result with ov_rdata=TIMEOUT_DATA and err=1. ov_timeout_cnt increments and saturates at 16'hFFFF.
- Match and timeout in the same cycle: the match wins.
- After a result: decrement beats. If beats remain, address += i_cmd_incr; 19-bit wrap 19'h7FFFF -> 0. Then -> RD_REQ. Otherwise -> IDLE with o_cmd_ready=1 next cycle.
- Strobes o_wr/o_rd are never asserted together. Bus outputs return to 0 in every cycle without a strobe.
- Asynchronous reset mid-burst aborts the burst: no partial result, no last flag.
- Throughput: single read beat = 3 cycles minimum (REQ, response, result); write = 2 cycles including accept.

Optional Feature:
HCP_WR_READBACK_EN
- Defined: after WR, the FSM issues a read to the same addr/fixed and waits using RD_WAIT rules. The read data is compared with the written data; no o_rdata_valid result is emitted. A mismatch or timeout gives a one-cycle pulse on an extra output o_wr_verify_err, and o_cmd_ready returns afterward.
- Undefined: WR -> IDLE directly; o_wr_verify_err is absent.

Decomposition:
- Shared package hcp_pkg holds:
  - command type codes CMD_WR=2'b01, CMD_RD=2'b10
  - FSM state encoding
  - ADDR_W
  - TIMEOUT_DATA default
- One sub-module, hcp_rd_timer: a wait counter with clear/enable and a timeout flag, plus the saturating 16-bit timeout counter. All other logic stays in the top module.

Test Plan:
- Write type=01, addr=4, fixed=0, wdata=3 -> one-cycle o_wr with addr 4 and wdata 3, o_rd=0, no result, ready back 2 cycles after accept.
- Read burst type=10, addr=0, num=3, incr=1, responder returns 0x00000000/0x00003410/0x00800001 one cycle after each o_rd -> three results with addrs 0,1,2; last only on the third; err=0.
- Read addr=9 with no responder -> after RD_TIMEOUT=16 wait cycles, result 0xDEADBEEF with err=1 and last=1; ov_timeout_cnt goes 0 -> 1.
- Stray response with addr 7 during a read of addr 3, then the correct response -> the stray is ignored; a single result carries addr 3 and the correct data.
- Read num=2, incr=0, addr=19'h7FFFF; then incr=1 -> both beats use 7FFFF; the incrementing case wraps to address 0.
- type=2'b11 -> o_illegal_cmd pulses, no strobes; reset asserted mid-burst -> all outputs 0 immediately and o_cmd_ready=1 after release.

Source files
------------

// File: rtl/hcp_pkg.sv
// ---------------------------------------------------------------------------
// hcp_pkg
// Shared definitions for the HCP register-access initiator:
//   - command type codes (CMD_WR, CMD_RD)
//   - initiator FSM state encoding
//   - default bus address width and timed-out read data word
//   - beats_init(): read burst length with a zero length mapped to one beat
// ---------------------------------------------------------------------------
package hcp_pkg;

    localparam int          ADDR_W           = 19;
    localparam logic [1:0]  CMD_WR           = 2'b01;
    localparam logic [1:0]  CMD_RD           = 2'b10;
    localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_REQ  = 2'd2,
        ST_RD_WAIT = 2'd3
    } hcp_state_e;

    // A burst length of zero still performs one read beat.
    function automatic logic [7:0] beats_init(input logic [7:0] num);
        logic [7:0] beats;
        if (num == 8'd0) begin
            beats = 8'd1;
        end else begin
            beats = num;
        end
        return beats;
    endfunction

endpackage

// File: rtl/hcp_rd_timer.sv
// ---------------------------------------------------------------------------
// hcp_rd_timer
// Read-response wait counter plus saturating timeout event counter.
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_clr           : restart the wait counter (issued while the read strobe goes out)
//   i_en            : one wait cycle elapsed without a matching response
//   i_inc           : a timeout was declared; bump the event counter
//   o_timeout       : current wait cycle is the RD_TIMEOUT-th one
//   ov_timeout_cnt  : number of timeouts, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module hcp_rd_timer #(
    parameter int RD_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic        i_inc,
    output logic        o_timeout,
    output logic [15:0] ov_timeout_cnt
);

    logic [7:0] wait_cnt_r;

    // Flag on the last permitted wait cycle so the result follows on the next edge.
    assign o_timeout = i_en && (wait_cnt_r >= 8'(RD_TIMEOUT - 1));

    // Wait-cycle counter; holds at its ceiling rather than wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt_r <= 8'd0;
        end else if (i_clr) begin
            wait_cnt_r <= 8'd0;
        end else if (i_en && (wait_cnt_r != 8'hFF)) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Timeout event counter, saturating.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_timeout_cnt <= 16'd0;
        end else if (i_inc && (ov_timeout_cnt != 16'hFFFF)) begin
            ov_timeout_cnt <= ov_timeout_cnt + 16'd1;
        end else begin
            ov_timeout_cnt <= ov_timeout_cnt;
        end
    end

endmodule

// File: rtl/hcp_reg_access_initiator.sv
// ---------------------------------------------------------------------------
// hcp_reg_access_initiator
// Master of the HCP register-access bus. Accepts decoded TSMP commands
// (single write, or read burst with fixed/incrementing address), drives
// o_wr/o_rd strobes to the register groups, collects read responses with a
// timeout, and streams read results to the TSMP encapsulator.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready       command handshake (ready = idle)
//   iv_cmd_type/addr/wdata/num      command fields, i_cmd_addr_fixed, i_cmd_incr
//   o_wr, o_rd, ov_addr,
//   o_addr_fixed, ov_wdata          register bus (all zero outside a strobe)
//   i_resp_valid, iv_resp_addr,
//   i_resp_addr_fixed, iv_resp_rdata read response from the register groups
//   o_rdata_valid/addr/rdata/err/last one-cycle read result
//   ov_timeout_cnt                  saturating count of read timeouts
//   o_illegal_cmd                   pulse on an unknown command type
//
// Build option HCP_WR_READBACK_EN: every write is followed by a read of the
// same location; a data mismatch or timeout pulses o_wr_verify_err and no
// read result is emitted for the verification read.
// ---------------------------------------------------------------------------
module hcp_reg_access_initiator #(
    parameter int          RD_TIMEOUT   = 16,
    parameter logic [31:0] TIMEOUT_DATA = hcp_pkg::TIMEOUT_DATA_DEF,
    parameter int          ADDR_W       = hcp_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        iv_cmd_type,
    input  logic [ADDR_W-1:0] iv_cmd_addr,
    input  logic              i_cmd_addr_fixed,
    input  logic [31:0]       iv_cmd_wdata,
    input  logic [7:0]        iv_cmd_num,
    input  logic              i_cmd_incr,
    output logic              o_wr,
    output logic              o_rd,
    output logic [ADDR_W-1:0] ov_addr,
    output logic              o_addr_fixed,
    output logic [31:0]       ov_wdata,
    input  logic              i_resp_valid,
    input  logic [ADDR_W-1:0] iv_resp_addr,
    input  logic              i_resp_addr_fixed,
    input  logic [31:0]       iv_resp_rdata,
    output logic              o_rdata_valid,
    output logic [ADDR_W-1:0] ov_rdata_addr,
    output logic [31:0]       ov_rdata,
    output logic              o_rdata_err,
    output logic              o_rdata_last,
    output logic [15:0]       ov_timeout_cnt,
    output logic              o_illegal_cmd
`ifdef HCP_WR_READBACK_EN
    ,
    output logic              o_wr_verify_err
`endif
);

    import hcp_pkg::*;

    hcp_state_e        state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              fixed_r, fixed_s;
    logic              incr_r, incr_s;
    logic [7:0]        beats_r, beats_s;

    logic              ready_s, wr_s, rd_s, bus_fixed_s;
    logic [ADDR_W-1:0] bus_addr_s;
    logic [31:0]       bus_wdata_s;
    logic              rvalid_s, rerr_s, rlast_s, illegal_s;
    logic [ADDR_W-1:0] raddr_s;
    logic [31:0]       rdata_s;

    logic              match_s, timeout_s;
    logic              tmr_clr_s, tmr_en_s, tmr_inc_s;

`ifdef HCP_WR_READBACK_EN
    logic [31:0]       wdata_r, wdata_s;
    logic              verify_r, verify_s;
    logic              verr_s;
`endif

    // A response counts only if it echoes the address and space of the outstanding read.
    assign match_s = i_resp_valid && (iv_resp_addr == addr_r) &&
                     (i_resp_addr_fixed == fixed_r);

    hcp_rd_timer #(
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_rd_timer (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_clr          (tmr_clr_s),
        .i_en           (tmr_en_s),
        .i_inc          (tmr_inc_s),
        .o_timeout      (timeout_s),
        .ov_timeout_cnt (ov_timeout_cnt)
    );

    // Next-state and next-output logic; every output is the registered image of these values.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        fixed_s     = fixed_r;
        incr_s      = incr_r;
        beats_s     = beats_r;
        ready_s     = 1'b0;
        wr_s        = 1'b0;
        rd_s        = 1'b0;
        bus_addr_s  = '0;
        bus_fixed_s = 1'b0;
        bus_wdata_s = 32'd0;
        rvalid_s    = 1'b0;
        raddr_s     = '0;
        rdata_s     = 32'd0;
        rerr_s      = 1'b0;
        rlast_s     = 1'b0;
        illegal_s   = 1'b0;
        tmr_clr_s   = 1'b0;
        tmr_en_s    = 1'b0;
        tmr_inc_s   = 1'b0;
`ifdef HCP_WR_READBACK_EN
        wdata_s     = wdata_r;
        verify_s    = verify_r;
        verr_s      = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
                if (i_cmd_valid) begin
                    addr_s  = iv_cmd_addr;
                    fixed_s = i_cmd_addr_fixed;
                    incr_s  = i_cmd_incr;
`ifdef HCP_WR_READBACK_EN
                    wdata_s = iv_cmd_wdata;
`endif
                    if (iv_cmd_type == CMD_WR) begin
                        // Strobe is set on the accepting edge so the write costs two cycles.
                        state_s     = ST_WR;
                        ready_s     = 1'b0;
                        wr_s        = 1'b1;
                        bus_addr_s  = iv_cmd_addr;
                        bus_fixed_s = i_cmd_addr_fixed;
                        bus_wdata_s = iv_cmd_wdata;
                    end else if (iv_cmd_type == CMD_RD) begin
                        state_s     = ST_RD_REQ;
                        ready_s     = 1'b0;
                        rd_s        = 1'b1;
                        bus_addr_s  = iv_cmd_addr;
                        bus_fixed_s = i_cmd_addr_fixed;
                        beats_s     = beats_init(iv_cmd_num);
                    end else begin
                        illegal_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR: begin
`ifdef HCP_WR_READBACK_EN
                state_s     = ST_RD_REQ;
                verify_s    = 1'b1;
                beats_s     = 8'd1;
                rd_s        = 1'b1;
                bus_addr_s  = addr_r;
                bus_fixed_s = fixed_r;
`else
                state_s = ST_IDLE;
                ready_s = 1'b1;
`endif
            end
            ST_RD_REQ: begin
                tmr_clr_s = 1'b1;
                state_s   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                tmr_en_s = 1'b1;
                if (match_s || timeout_s) begin
                    // A match in the timeout cycle still counts as a good read.
                    tmr_inc_s = !match_s;
                    rdata_s   = match_s ? iv_resp_rdata : TIMEOUT_DATA;
                    rerr_s    = !match_s;
`ifdef HCP_WR_READBACK_EN
                    if (verify_r) begin
                        verr_s   = !match_s || (iv_resp_rdata != wdata_r);
                        verify_s = 1'b0;
                        rdata_s  = 32'd0;
                        rerr_s   = 1'b0;
                        beats_s  = 8'd0;
                        state_s  = ST_IDLE;
                        ready_s  = 1'b1;
                    end else
`endif
                    begin
                        rvalid_s = 1'b1;
                        raddr_s  = addr_r;
                        rlast_s  = (beats_r == 8'd1);
                        if (beats_r == 8'd1) begin
                            beats_s = 8'd0;
                            state_s = ST_IDLE;
                            ready_s = 1'b1;
                        end else begin
                            // Next beat's request overlaps this result cycle.
                            beats_s     = beats_r - 8'd1;
                            addr_s      = addr_r + ADDR_W'(incr_r);
                            state_s     = ST_RD_REQ;
                            rd_s        = 1'b1;
                            bus_addr_s  = addr_s;
                            bus_fixed_s = fixed_r;
                        end
                    end
                end else begin
                    state_s = ST_RD_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                ready_s = 1'b1;
            end
        endcase
    end

    // State, command context and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= ST_IDLE;
            addr_r        <= '0;
            fixed_r       <= 1'b0;
            incr_r        <= 1'b0;
            beats_r       <= 8'd0;
            o_cmd_ready   <= 1'b1;
            o_wr          <= 1'b0;
            o_rd          <= 1'b0;
            ov_addr       <= '0;
            o_addr_fixed  <= 1'b0;
            ov_wdata      <= 32'd0;
            o_rdata_valid <= 1'b0;
            ov_rdata_addr <= '0;
            ov_rdata      <= 32'd0;
            o_rdata_err   <= 1'b0;
            o_rdata_last  <= 1'b0;
            o_illegal_cmd <= 1'b0;
`ifdef HCP_WR_READBACK_EN
            wdata_r         <= 32'd0;
            verify_r        <= 1'b0;
            o_wr_verify_err <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            addr_r        <= addr_s;
            fixed_r       <= fixed_s;
            incr_r        <= incr_s;
            beats_r       <= beats_s;
            o_cmd_ready   <= ready_s;
            o_wr          <= wr_s;
            o_rd          <= rd_s;
            ov_addr       <= bus_addr_s;
            o_addr_fixed  <= bus_fixed_s;
            ov_wdata      <= bus_wdata_s;
            o_rdata_valid <= rvalid_s;
            ov_rdata_addr <= raddr_s;
            ov_rdata      <= rdata_s;
            o_rdata_err   <= rerr_s;
            o_rdata_last  <= rlast_s;
            o_illegal_cmd <= illegal_s;
`ifdef HCP_WR_READBACK_EN
            wdata_r         <= wdata_s;
            verify_r        <= verify_s;
            o_wr_verify_err <= verr_s;
`endif
        end
    end

endmodule
